// File: rtl/wave_osc.sv
// Purpose : NCO audio voice producing square/saw/triangle samples scaled by an 8-bit gain.
// Latency : sample/sample_valid update on the 2nd clock edge after each divider tick edge.
// Backpressure: none; the consumer must accept every sample_valid pulse (one per CLK_DIV cycles).
//
// Ports:
//   clk, rst_n          - system clock (rising edge), asynchronous active-low reset
//   enable              - run the divider/phase accumulator; low forces both to zero
//   load                - strobe capturing freq_word/wave_sel/amplitude into pending regs
//   freq_word           - phase increment per sample period
//   wave_sel            - 00 silence, 01 square, 10 saw, 11 triangle
//   amplitude           - unsigned gain, sample = raw*amplitude/256 (floor)
//   sample              - registered signed sample, held between updates
//   sample_valid        - one-cycle pulse on each sample update
//   phase_wrap          - set with sample_valid when that sample's phase update carried out
module wave_osc #(
  parameter int CLK_DIV = 1134,
  parameter int PHASE_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                load,
  input  logic [PHASE_W-1:0]  freq_word,
  input  logic [1:0]          wave_sel,
  input  logic [7:0]          amplitude,
  output logic signed [15:0]  sample,
  output logic                sample_valid,
  output logic                phase_wrap
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0]   count;
  logic               tick;
  logic [PHASE_W-1:0] phase;
  logic               wrap0;

  logic [PHASE_W-1:0] freq_pend, freq_act;
  logic [1:0]         wave_pend, wave_act;
  logic [7:0]         amp_pend,  amp_act;

  logic               v1, v2;
  logic               wrap1;
  logic signed [15:0] raw_next, raw;
  logic signed [24:0] prod;

  logic [15:0] p;
  logic [14:0] tri_t;

  assign tick = enable && (count == CNT_LAST);

  // Divider and phase accumulator; both are held at zero while stopped so a
  // restart always begins a full period later from phase 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      phase <= '0;
      wrap0 <= 1'b0;
    end else if (!enable) begin
      count <= '0;
      phase <= '0;
    end else if (tick) begin
      count <= '0;
      {wrap0, phase} <= {1'b0, phase} + {1'b0, freq_act};
    end else begin
      count <= count + 1'b1;
    end
  end

  // Double-buffered controls: pending captures at any time, active copies on
  // a tick. A load on the tick edge lands in pending only, so it applies next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_pend <= '0;
      wave_pend <= '0;
      amp_pend  <= '0;
      freq_act  <= '0;
      wave_act  <= '0;
      amp_act   <= '0;
    end else begin
      if (load) begin
        freq_pend <= freq_word;
        wave_pend <= wave_sel;
        amp_pend  <= amplitude;
      end
      if (tick) begin
        freq_act <= freq_pend;
        wave_act <= wave_pend;
        amp_act  <= amp_pend;
      end
    end
  end

  // Waveform shaping from the top 16 phase bits.
  assign p     = phase[PHASE_W-1 -: 16];
  assign tri_t = p[15] ? ~p[14:0] : p[14:0];

  always_comb begin
    raw_next = '0;
    case (wave_act)
      2'b01:   raw_next = p[15] ? 16'sh8000 : 16'sh7fff;
      2'b10:   raw_next = $signed(p ^ 16'h8000);
      2'b11:   raw_next = $signed({tri_t, 1'b0} ^ 16'h8000);
      default: raw_next = '0;
    endcase
  end

  // Gain is zero-extended to keep it positive in the signed product.
  assign prod = raw * $signed({1'b0, amp_act});

  // Stage 1 registers the raw shape, stage 2 the scaled sample. The pipeline
  // drains even if enable drops meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      wrap1        <= 1'b0;
      raw          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      phase_wrap   <= 1'b0;
    end else begin
      v1           <= tick;
      v2           <= v1;
      sample_valid <= v2;
      phase_wrap   <= v2 & wrap1;
      if (v1) begin
        raw   <= raw_next;
        wrap1 <= wrap0;
      end
      if (v2) begin
        sample <= 16'(prod >>> 8);
      end
    end
  end

endmodule

// File: tb/tb_wave_osc.sv
module tb_wave_osc;
  localparam int CLK_DIV = 4;
  localparam int PW      = 24;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic               load = 1'b0;
  logic [PW-1:0]      freq_word = '0;
  logic [1:0]         wave_sel = '0;
  logic [7:0]         amplitude = '0;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               phase_wrap;

  wave_osc #(.CLK_DIV(CLK_DIV), .PHASE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .freq_word(freq_word), .wave_sel(wave_sel), .amplitude(amplitude),
    .sample(sample), .sample_valid(sample_valid), .phase_wrap(phase_wrap)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int val; int wrap; } exp_t;
  exp_t exp_q[$];

  int     m_cnt = 0;
  longint m_phase = 0;
  longint m_pf = 0, m_af = 0;
  int     m_pw = 0, m_aw = 0, m_pa = 0, m_aa = 0;
  int     edge_n = 0;
  int     last_sample = 0;

  int obs_s[$];
  int obs_w[$];

  function automatic int wave_val(int w, int p, int a);
    int raw;
    int prod;
    case (w)
      1: raw = (p < 32768) ? 32767 : -32768;
      2: raw = p - 32768;
      3: raw = (p < 32768) ? (2 * p - 32768) : (2 * (65535 - p) - 32768);
      default: raw = 0;
    endcase
    prod = raw * a;
    return (prod >= 0) ? (prod / 256) : -((-prod + 255) / 256);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_phase = 0; m_pf = 0; m_af = 0;
      m_pw = 0; m_aw = 0; m_pa = 0; m_aa = 0;
      last_sample = 0;
      exp_q.delete();
    end else begin
      bit     tk;
      longint s;
      exp_t   e;
      edge_n++;
      tk = enable && (m_cnt == CLK_DIV - 1);
      if (tk) begin
        s       = m_phase + m_af;
        e.wrap  = int'(s >> PW);
        m_phase = s % (64'd1 << PW);
        m_af = m_pf; m_aw = m_pw; m_aa = m_pa;
        e.due = edge_n + 2;
        e.val = wave_val(m_aw, int'(m_phase >> (PW - 16)), m_aa);
        exp_q.push_back(e);
      end
      if (load) begin
        m_pf = longint'(freq_word); m_pw = int'(wave_sel); m_pa = int'(amplitude);
      end
      if (!enable) begin
        m_cnt = 0; m_phase = 0;
      end else if (tk) m_cnt = 0;
      else m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      obs_s.push_back(int'(sample));
      obs_w.push_back(int'(phase_wrap));
    end
    if (!rst_n) begin
      check("rst_sample", sample, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_wrap", phase_wrap, 0);
    end else if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
      check("pulse_valid", sample_valid, 1);
      check("pulse_sample", sample, exp_q[0].val);
      check("pulse_wrap", phase_wrap, exp_q[0].wrap);
      last_sample = exp_q[0].val;
      void'(exp_q.pop_front());
    end else begin
      check("idle_valid", sample_valid, 0);
      check("idle_wrap", phase_wrap, 0);
      check("hold_sample", sample, last_sample);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (obs_s.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check("pulse_timeout", (obs_s.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic do_load(input logic [PW-1:0] f, input logic [1:0] w, input logic [7:0] a);
    freq_word = f; wave_sel = w; amplitude = a; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic align_tick();
    int k = 0;
    while (m_cnt != CLK_DIV - 1 && k < 4 * CLK_DIV) begin
      step(1);
      k++;
    end
    check("align_timeout", m_cnt, CLK_DIV - 1);
  endtask

  initial begin
    int tri_pat[4];
    int k;
    tri_pat = '{-32640, 0, 32638, -2};

    // 1: reset with toggling inputs, then idle while disabled
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      enable = 1'($urandom); load = 1'($urandom);
      freq_word = PW'($urandom); wave_sel = 2'($urandom); amplitude = 8'($urandom);
      step(1);
    end
    enable = 1'b0; load = 1'b0;
    rst_n = 1'b1;
    obs_s.delete(); obs_w.delete();
    step(100);
    check("t1_no_valid", obs_s.size(), 0);

    // 2: saw ramp, wrap on the 17th sample
    do_load(24'h100000, 2'b10, 8'd255);
    enable = 1'b1;
    wait_pulses(17, 17 * CLK_DIV + 20);
    check("t2_s0", obs_s[0], -32640);
    check("t2_s1", obs_s[1], -28560);
    check("t2_s16", obs_s[16], -32640);
    check("t2_w0", obs_w[0], 0);
    check("t2_w15", obs_w[15], 0);
    check("t2_w16", obs_w[16], 1);

    // 3: square at half amplitude
    enable = 1'b0; step(5);
    do_load(24'h800000, 2'b01, 8'd128);
    obs_s.delete(); obs_w.delete();
    enable = 1'b1;
    wait_pulses(4, 4 * CLK_DIV + 20);
    check("t3_s0", obs_s[0], 16383);
    check("t3_s1", obs_s[1], -16384);
    check("t3_s2", obs_s[2], 16383);
    check("t3_s3", obs_s[3], -16384);

    // 4: triangle quarter-period steps (first phase is one old step of 0x800000)
    enable = 1'b0; step(5);
    do_load(24'h400000, 2'b11, 8'd255);
    obs_s.delete(); obs_w.delete();
    enable = 1'b1;
    wait_pulses(8, 8 * CLK_DIV + 20);
    for (int i = 0; i < 8; i++) check($sformatf("t4_s%0d", i), obs_s[i], tri_pat[(i + 2) % 4]);

    // 5: load coinciding with a tick applies one sample late
    enable = 1'b0; step(5);
    do_load(24'h000000, 2'b01, 8'd255);
    enable = 1'b1;
    obs_s.delete(); obs_w.delete();
    wait_pulses(3, 3 * CLK_DIV + 20);
    align_tick();
    amplitude = 8'd64; load = 1'b1;
    step(1);
    load = 1'b0;
    obs_s.delete(); obs_w.delete();
    wait_pulses(2, 2 * CLK_DIV + 20);
    check("t5_old_amp", obs_s[0], 32639);
    check("t5_new_amp", obs_s[1], 8191);

    // 6: drop enable with a sample in flight, then restart
    enable = 1'b0; step(5);
    do_load(24'h100000, 2'b10, 8'd255);
    enable = 1'b1;
    obs_s.delete(); obs_w.delete();
    wait_pulses(3, 3 * CLK_DIV + 20);
    align_tick();
    obs_s.delete(); obs_w.delete();
    step(1);
    enable = 1'b0;
    step(10);
    check("t6_inflight", obs_s.size(), 1);
    obs_s.delete(); obs_w.delete();
    enable = 1'b1;
    k = 0;
    while (obs_s.size() == 0 && k < 50) begin
      step(1);
      k++;
    end
    check("t6_latency", k, CLK_DIV + 2);
    if (obs_s.size() > 0) check("t6_first", obs_s[0], -28560);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        freq_word = PW'($urandom); wave_sel = 2'($urandom); amplitude = 8'($urandom);
        load = 1'b1;
      end else load = 1'b0;
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0; step(2); rst_n = 1'b1;
      end
      step(1);
    end
    load = 1'b0;
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
